// File: rtl/count_scheduler_pkg.sv
// Shared types for count_scheduler: FSM state encoding and the round-robin pointer increment.
package count_scheduler_pkg;

   localparam int unsigned StateW = 2;

   localparam logic [StateW-1:0] EncIdle = 2'd0;
   localparam logic [StateW-1:0] EncRun  = 2'd1;
   localparam logic [StateW-1:0] EncDone = 2'd2;

   typedef enum logic [StateW-1:0] {
      StIdle = EncIdle,
      StRun  = EncRun,
      StDone = EncDone
   } state_e;

   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/count_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, modulo N_REQ.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IdxW-1:0]  ptr_i,
   output logic [N_REQ-1:0] onehot_o,
   output logic [IdxW-1:0]  idx_o,
   output logic             valid_o
);

   always_comb begin
      int unsigned c;
      c        = 0;
      onehot_o = '0;
      idx_o    = '0;
      valid_o  = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         c = (32'(ptr_i) + k) % N_REQ;
         if (!valid_o && req_i[IdxW'(c)]) begin
            valid_o              = 1'b1;
            idx_o                = IdxW'(c);
            onehot_o[IdxW'(c)]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/count_scheduler.sv
// Round-robin owner of one shared up-counter; runs 0..len for the granted requester.
// Optional build macro COUNT_SCHEDULER_ABORT_EN lets the owner abandon a run by dropping req.
module count_scheduler
   import count_scheduler_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned N_REQ = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] len,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy,
   output logic [WIDTH-1:0]       count,
   output logic [N_REQ-1:0]       done
);

   localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic [IdxW-1:0]  ptr_q, ptr_d;
   logic [IdxW-1:0]  owner_q, owner_d;

   logic [N_REQ-1:0] pick_onehot;
   logic [IdxW-1:0]  pick_idx;
   logic             pick_valid;
   logic [WIDTH-1:0] len_arr [N_REQ];
   logic [IdxW-1:0]  ptr_next;
   logic             run_kept;

   for (genvar g = 0; g < N_REQ; g++) begin : g_len
      assign len_arr[g] = len[g*WIDTH +: WIDTH];
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .IdxW  (IdxW)
   ) u_pick (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .valid_o  (pick_valid)
   );

   assign ptr_next = IdxW'(ptr_inc(32'(owner_q), N_REQ));

`ifdef COUNT_SCHEDULER_ABORT_EN
   assign run_kept = req[owner_q];
`else
   assign run_kept = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      busy_d  = busy_q;
      count_d = count_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      unique case (state_q)
         StIdle: begin
            grant_d = '0;
            busy_d  = 1'b0;
            count_d = '0;
            if (pick_valid) begin
               state_d = StRun;
               grant_d = pick_onehot;
               busy_d  = 1'b1;
               len_d   = len_arr[pick_idx];
               owner_d = pick_idx;
            end
         end
         StRun: begin
            if (!run_kept) begin
               // Abandoned run: release without a done pulse, still rotate past the owner.
               state_d = StIdle;
               grant_d = '0;
               busy_d  = 1'b0;
               count_d = '0;
               ptr_d   = ptr_next;
            end else if (count_q == len_q) begin
               state_d = StDone;
               done_d  = grant_q;
               grant_d = '0;
               busy_d  = 1'b0;
               count_d = '0;
               ptr_d   = ptr_next;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
            grant_d = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
            busy_d  = 1'b0;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         count_q <= '0;
         len_q   <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         len_q   <= len_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign count = count_q;

endmodule

// File: tb/tb_count_scheduler.sv
// Self-checking bench for count_scheduler; grant/done events are scored against a queue.
module tb_count_scheduler;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned N_REQ = 4;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] len;
   logic [N_REQ-1:0]       grant;
   logic                   busy;
   logic [WIDTH-1:0]       count;
   logic [N_REQ-1:0]       done;

   int checks = 0;
   int errors = 0;

   logic [N_REQ-1:0] exp_grant [$];
   logic [N_REQ-1:0] exp_done  [$];
   logic [N_REQ-1:0] prev_grant = '0;
   logic [N_REQ-1:0] sb_exp;

   count_scheduler #(
      .WIDTH (WIDTH),
      .N_REQ (N_REQ)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .len   (len),
      .grant (grant),
      .busy  (busy),
      .count (count),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Scoreboard: each new grant and each done pulse must match the next expected entry.
   always @(negedge clk) begin
      if (!reset) begin
         if (grant !== '0 && prev_grant === '0) begin
            checks++;
            if (exp_grant.size() == 0) begin
               errors++;
               $display("FAIL grant_sb: got %b, expected no grant", grant);
            end else begin
               sb_exp = exp_grant.pop_front();
               if (grant !== sb_exp) begin
                  errors++;
                  $display("FAIL grant_sb: got %b, expected %b", grant, sb_exp);
               end
            end
         end
         if (done !== '0) begin
            checks++;
            if (exp_done.size() == 0) begin
               errors++;
               $display("FAIL done_sb: got %b, expected no done", done);
            end else begin
               sb_exp = exp_done.pop_front();
               if (done !== sb_exp) begin
                  errors++;
                  $display("FAIL done_sb: got %b, expected %b", done, sb_exp);
               end
            end
         end
      end
      prev_grant = grant;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_len(input int i, input logic [WIDTH-1:0] v);
      len[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      len   = '0;
      step(2);
      reset = 1'b0;
   endtask

   task automatic serve(input int n_done, input bit drop_each);
      int seen = 0;
      int cyc  = 0;
      while (seen < n_done && cyc < 200) begin
         step(1);
         cyc++;
         if (done !== '0) begin
            seen++;
            if (drop_each) req = req & ~done;
            if (seen == n_done) req = '0;
         end
      end
      checks++;
      if (seen != n_done) begin
         errors++;
         $display("FAIL serve_timeout: got %0d done pulses, expected %0d", seen, n_done);
      end
      step(2);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({grant, busy, count, done} !== '0) begin
         errors++;
         $display("FAIL reset_state: got grant=%b busy=%b count=%h done=%b, expected all zero",
                  grant, busy, count, done);
      end
   endtask

   task automatic test_single();
      set_len(0, 4'd3);
      req = 4'b0001;
      exp_grant.push_back(4'b0001);
      exp_done.push_back(4'b0001);
      step(1);
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1 || count !== 4'd0) begin
         errors++;
         $display("FAIL single_grant: got grant=%b busy=%b count=%h, expected 0001 1 0",
                  grant, busy, count);
      end
      for (int i = 1; i <= 3; i++) begin
         step(1);
         checks++;
         if (count !== WIDTH'(i) || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_count: got count=%h busy=%b, expected %h 1", count, busy, i);
         end
      end
      step(1);
      checks++;
      if (done !== 4'b0001 || busy !== 1'b0 || grant !== 4'b0000) begin
         errors++;
         $display("FAIL single_done: got done=%b busy=%b grant=%b, expected 0001 0 0000",
                  done, busy, grant);
      end
      req = '0;
      step(2);
   endtask

   task automatic test_round_robin();
      do_reset();
      len = '0;
      foreach (exp_grant[i]) ;
      exp_grant.push_back(4'b0001); exp_done.push_back(4'b0001);
      exp_grant.push_back(4'b0010); exp_done.push_back(4'b0010);
      exp_grant.push_back(4'b0100); exp_done.push_back(4'b0100);
      exp_grant.push_back(4'b1000); exp_done.push_back(4'b1000);
      exp_grant.push_back(4'b0001); exp_done.push_back(4'b0001);
      req = 4'b1111;
      serve(5, 1'b0);
   endtask

   task automatic test_ptr();
      do_reset();
      len = '0;
      exp_grant.push_back(4'b0001); exp_done.push_back(4'b0001);
      req = 4'b0001;
      serve(1, 1'b1);
      exp_grant.push_back(4'b0100); exp_done.push_back(4'b0100);
      exp_grant.push_back(4'b0001); exp_done.push_back(4'b0001);
      req = 4'b0101;
      serve(2, 1'b1);
   endtask

   task automatic test_max_len();
      do_reset();
      set_len(1, 4'hF);
      req = 4'b0010;
      exp_grant.push_back(4'b0010);
      exp_done.push_back(4'b0010);
      step(1);
      checks++;
      if (grant !== 4'b0010 || count !== 4'h0) begin
         errors++;
         $display("FAIL max_grant: got grant=%b count=%h, expected 0010 0", grant, count);
      end
      for (int i = 1; i <= 15; i++) begin
         step(1);
         checks++;
         if (count !== WIDTH'(i) || done !== '0) begin
            errors++;
            $display("FAIL max_count: got count=%h done=%b, expected %h 0000", count, done, i);
         end
      end
      step(1);
      checks++;
      if (done !== 4'b0010 || busy !== 1'b0) begin
         errors++;
         $display("FAIL max_done: got done=%b busy=%b, expected 0010 0", done, busy);
      end
      req = '0;
      step(2);
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      set_len(2, 4'd5);
      req = 4'b0100;
      exp_grant.push_back(4'b0100);
      step(3);
      checks++;
      if (count !== 4'd2 || grant !== 4'b0100) begin
         errors++;
         $display("FAIL midrun_count: got count=%h grant=%b, expected 2 0100", count, grant);
      end
      reset = 1'b1;
      req   = '0;
      step(1);
      checks++;
      if ({grant, busy, count, done} !== '0) begin
         errors++;
         $display("FAIL midrun_reset: got grant=%b busy=%b count=%h done=%b, expected all zero",
                  grant, busy, count, done);
      end
      reset = 1'b0;
      step(10);
   endtask

   task automatic test_abort();
      do_reset();
      set_len(0, 4'd6);
      req = 4'b0001;
      exp_grant.push_back(4'b0001);
`ifndef COUNT_SCHEDULER_ABORT_EN
      exp_done.push_back(4'b0001);
`endif
      step(2);
      checks++;
      if (count !== 4'd1) begin
         errors++;
         $display("FAIL abort_count: got count=%h, expected 1", count);
      end
      req = '0;
`ifdef COUNT_SCHEDULER_ABORT_EN
      step(1);
      checks++;
      if ({grant, busy, count, done} !== '0) begin
         errors++;
         $display("FAIL abort_release: got grant=%b busy=%b count=%h done=%b, expected all zero",
                  grant, busy, count, done);
      end
      step(1);
`else
      serve(1, 1'b1);
`endif
      exp_grant.push_back(4'b0010);
      exp_done.push_back(4'b0010);
      req = 4'b0011;
      serve(1, 1'b1);
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      len   = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_ptr();
      test_max_len();
      test_reset_mid_run();
      test_abort();
      checks++;
      if (exp_grant.size() != 0 || exp_done.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d grants and %0d dones outstanding, expected 0 and 0",
                  exp_grant.size(), exp_done.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
